// File: rtl/mpe_column_seq_if.sv
// Handshake bundle for the systolic MAC column: weight preload, input vectors and psum results.
interface mpe_column_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int NUMBER_PE  = 9
);
  logic                            i_w_load;
  logic                            i_w_valid;
  logic [DATA_WIDTH-1:0]           i_w_data;
  logic                            o_w_ready;
  logic                            i_valid;
  logic                            o_in_ready;
  logic [NUMBER_PE*DATA_WIDTH-1:0] i_fmap;
  logic [ACC_WIDTH-1:0]            i_bias;
  logic                            o_valid;
  logic                            i_out_ready;
  logic [ACC_WIDTH-1:0]            o_psum;
  logic [1:0]                      o_state;

  modport slave (
    input  i_w_load, i_w_valid, i_w_data, i_valid, i_fmap, i_bias, i_out_ready,
    output o_w_ready, o_in_ready, o_valid, o_psum, o_state
  );

  modport master (
    output i_w_load, i_w_valid, i_w_data, i_valid, i_fmap, i_bias, i_out_ready,
    input  o_w_ready, o_in_ready, o_valid, o_psum, o_state
  );
endinterface

// File: rtl/mpe_column_seq.sv
// Systolic column of NUMBER_PE signed MAC stages with weight preload, input skew,
// full-pipeline stall and drain-before-reload sequencing.
//
// state | meaning
// IDLE  | weights cleared, waiting for a load request
// LOAD  | accepting NUMBER_PE weight beats, beat j -> PE j
// RUN   | accepting input vectors, pipeline streaming
// DRAIN | no new vectors, pipeline flushing before a reload
module mpe_column_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int NUMBER_PE  = 9
) (
  input logic               i_clk,
  input logic               i_rest_n,
  mpe_column_seq_if.slave   bus
);
  localparam int CW = $clog2(NUMBER_PE);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int WW = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                       state_q;
  logic [CW-1:0]                cnt_q;
  logic signed [DATA_WIDTH-1:0] w_q    [NUMBER_PE];
  logic signed [ACC_WIDTH-1:0]  psum_q [NUMBER_PE];
  logic [NUMBER_PE-1:0]         vld_q;
  logic signed [DATA_WIDTH-1:0] x_d    [NUMBER_PE];
  logic signed [ACC_WIDTH-1:0]  sum_d  [NUMBER_PE];
  logic                         adv;
  logic                         accept;

  assign adv            = !vld_q[NUMBER_PE-1] || bus.i_out_ready;
  assign bus.o_in_ready = (state_q == ST_RUN) && adv && !bus.i_w_load;
  assign accept         = bus.i_valid && bus.o_in_ready;
  assign bus.o_w_ready  = (state_q == ST_LOAD);
  assign bus.o_state    = state_q;
  assign bus.o_valid    = vld_q[NUMBER_PE-1];
  assign bus.o_psum     = psum_q[NUMBER_PE-1];

  // Element k is delayed k cycles so it meets its vector's psum at stage k.
  assign x_d[0] = bus.i_fmap[0 +: DATA_WIDTH];
  for (genvar k = 1; k < NUMBER_PE; k++) begin : g_skew
    logic signed [DATA_WIDTH-1:0] line_q [k];

    always_ff @(posedge i_clk or negedge i_rest_n) begin
      if (!i_rest_n) begin
        for (int i = 0; i < k; i++) line_q[i] <= '0;
      end else if (adv) begin
        line_q[0] <= bus.i_fmap[k*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i < k; i++) line_q[i] <= line_q[i-1];
      end
    end

    assign x_d[k] = line_q[k-1];
  end

  // Full-precision product, sign-extended (or wrapped) into the accumulator width.
  for (genvar k = 0; k < NUMBER_PE; k++) begin : g_pe
    logic signed [PW-1:0] prod;
    logic signed [WW-1:0] prod_w;

    assign prod   = PW'(w_q[k]) * PW'(x_d[k]);
    assign prod_w = WW'(prod);

    if (k == 0) begin : g_top
      assign sum_d[k] = $signed(bus.i_bias) + ACC_WIDTH'(prod_w);
    end else begin : g_chain
      assign sum_d[k] = psum_q[k-1] + ACC_WIDTH'(prod_w);
    end
  end

  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      vld_q <= '0;
      for (int k = 0; k < NUMBER_PE; k++) psum_q[k] <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[NUMBER_PE-2:0], accept};
      for (int k = 0; k < NUMBER_PE; k++) psum_q[k] <= sum_d[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int k = 0; k < NUMBER_PE; k++) w_q[k] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_w_load) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.i_w_valid) begin
            w_q[cnt_q] <= bus.i_w_data;
            if (cnt_q == CW'(NUMBER_PE - 1)) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_RUN: begin
          if (bus.i_w_load) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // o_valid is the last stage's valid bit, so this covers the output register too.
          if (vld_q == '0) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
